// File: rtl/board_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_ram_arbiter_if
// Requester-side bus of the board RAM arbiter. Three requesters share it:
// 0 = collision, 1 = add-to-RAM, 2 = line-clear.
//   req[2:0]     access request per requester
//   we[2:0]      write enable per requester (0 = read)
//   addr[23:0]   requester i address at [8i+7:8i]
//   wdata[17:0]  requester i write data at [6i+5:6i]
//   grant[2:0]   one-hot registered grant, or all zero
//   rvalid[2:0]  per-requester read-data-valid pulse
//   rdata[5:0]   shared read data, qualified by rvalid
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface board_ram_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [17:0] wdata;
    logic [2:0]  grant;
    logic [2:0]  rvalid;
    logic [5:0]  rdata;

    modport master (
        output req, we, addr, wdata,
        input  grant, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output grant, rvalid, rdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// board_ram_arbiter
// Round-robin arbiter giving three requesters access to the board RAM, with
// a bounded burst length and a board-clear sequence that zeroes every cell.
//   clk          clock, rising edge
//   reset_n      synchronous active-low reset
//   bus          requester bus (req/we/addr/wdata in, grant/rvalid/rdata out)
//   clear_start  single-cycle request to zero the whole board
//   clear_busy   high while the clear sequence runs
//   clear_done   one-cycle pulse when the clear completes
//   ram_addr     board RAM address
//   ram_data     board RAM write data
//   ram_wren     board RAM write enable
//   ram_q        board RAM read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module board_ram_arbiter #(
    parameter int unsigned NUM_CELLS = 200,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    board_ram_arbiter_if.slave        bus,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic [7:0]                ram_addr,
    output logic [5:0]                ram_data,
    output logic                      ram_wren,
    input  logic [5:0]                ram_q
);

    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [7:0]    CELL_LAST  = 8'(NUM_CELLS - 1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state;
    logic [2:0]    grant_q;
    logic [2:0]    rvalid_q;
    logic [1:0]    last_q;
    logic [BW-1:0] burst;
    logic [7:0]    clr_addr;
    logic          rd_oor;

    // Index of a one-hot grant vector.
    function automatic logic [1:0] enc(input logic [2:0] g);
        if (g[2])      return 2'd2;
        else if (g[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // First requesting bit in round-robin order, starting after 'last'.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = '0;
        for (int unsigned k = 1; k <= 3; k++) begin
            idx = 2'((32'(last) + k) % 3);
            if (pick == '0 && r[idx])
                pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    logic [1:0] own;
    logic       accept;
    logic [7:0] sel_addr;
    logic [5:0] sel_wdata;
    logic       sel_we;
    logic       in_range;
    logic       others;
    logic       release_own;
    logic [2:0] pick_new;
    logic [2:0] pick_handoff;

    assign own          = enc(grant_q);
    assign accept       = (state == ARB) && ((grant_q & bus.req) != '0);
    assign sel_addr     = bus.addr[8*own +: 8];
    assign sel_wdata    = bus.wdata[6*own +: 6];
    assign sel_we       = bus.we[own];
    assign in_range     = 32'(sel_addr) < NUM_CELLS;
    assign others       = (bus.req & ~grant_q) != '0;
    assign release_own  = !bus.req[own] || (burst == BURST_LAST && others);
    assign pick_new     = rr_pick(bus.req, last_q);
    // Excluding the releasing owner puts it at lowest priority on handoff.
    assign pick_handoff = rr_pick(bus.req & ~grant_q, own);

    assign bus.grant  = grant_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rd_oor ? '0 : ram_q;

    // RAM port muxing. Writes are blocked while reset_n is low so a reset
    // landing mid-clear leaves the current and remaining cells untouched.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        if (reset_n) begin
            if (state == CLEAR) begin
                ram_addr = clr_addr;
                ram_wren = 1'b1;
            end else if (accept) begin
                ram_addr = sel_addr;
                ram_data = sel_wdata;
                ram_wren = sel_we && in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ARB;
            grant_q    <= '0;
            rvalid_q   <= '0;
            last_q     <= 2'd2;   // requester 0 is first in round-robin order
            burst      <= '0;
            clr_addr   <= '0;
            rd_oor     <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            // Read responses are independent of the state change, so a read
            // accepted alongside clear_start still gets its rvalid.
            rvalid_q   <= (accept && !sel_we) ? grant_q : '0;
            rd_oor     <= accept && !sel_we && !in_range;

            case (state)
                ARB: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        grant_q    <= '0;
                        burst      <= '0;
                        clr_addr   <= '0;
                        clear_busy <= 1'b1;
                    end else if (grant_q != '0) begin
                        if (release_own) begin
                            grant_q <= pick_handoff;
                            burst   <= '0;
                            if (pick_handoff != '0)
                                last_q <= enc(pick_handoff);
                        end else if (burst != BURST_LAST) begin
                            burst <= burst + 1'b1;
                        end
                    end else begin
                        grant_q <= pick_new;
                        burst   <= '0;
                        if (pick_new != '0)
                            last_q <= enc(pick_new);
                    end
                end

                CLEAR: begin
                    if (clr_addr == CELL_LAST) begin
                        state      <= ARB;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        grant_q    <= pick_new;
                        burst      <= '0;
                        if (pick_new != '0)
                            last_q <= enc(pick_new);
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end

                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_ram_arbiter
// Directed bench for board_ram_arbiter with a behavioural board RAM and a
// read-response scoreboard.
// ---------------------------------------------------------------------------
module tb_board_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_start = 1'b0;
    logic       clear_busy, clear_done;
    logic [7:0] ram_addr;
    logic [5:0] ram_data, ram_q;
    logic       ram_wren;

    board_ram_arbiter_if bus();

    board_ram_arbiter #(.NUM_CELLS(200), .MAX_BURST(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    // Board RAM model with a backdoor preload port.
    logic [5:0] mem [0:255];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [5:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)        mem[pre_addr] <= pre_data;
        else if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    logic [5:0] exp_mem [0:255];

    typedef struct packed {
        logic [2:0] who;
        logic [5:0] data;
    } rd_t;
    rd_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid pulse pops one expected response.
    always @(negedge clk) begin
        rd_t e;
        if (reset_n && bus.rvalid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_who", 32'(bus.rvalid), 32'(e.who));
                check("rdata", 32'(bus.rdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int idx, input logic [5:0] d);
        rd_t e;
        e.who  = 3'(1 << idx);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.grant[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'(bus.grant), 32'(1 << idx));
    endtask

    task automatic do_read(input int idx, input logic [7:0] a);
        bit ok;
        bus.addr[8*idx +: 8] = a;
        bus.we[idx]  = 1'b0;
        bus.req[idx] = 1'b1;
        wait_grant(idx, ok);
        if (ok) begin
            check("rd_ram_addr", 32'(ram_addr), 32'(a));
            check("rd_ram_wren", 32'(ram_wren), 32'd0);
            push_rd(idx, (a < 8'd200) ? exp_mem[a] : 6'd0);
        end
        tick();
        bus.req[idx] = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_write(input int idx, input logic [7:0] a, input logic [5:0] d);
        bit ok;
        bus.addr[8*idx +: 8]  = a;
        bus.wdata[6*idx +: 6] = d;
        bus.we[idx]  = 1'b1;
        bus.req[idx] = 1'b1;
        wait_grant(idx, ok);
        if (ok) begin
            check("wr_ram_wren", 32'(ram_wren), (a < 8'd200) ? 32'd1 : 32'd0);
            if (a < 8'd200) begin
                check("wr_ram_addr", 32'(ram_addr), 32'(a));
                check("wr_ram_data", 32'(ram_data), 32'(d));
            end
        end
        tick();
        if (ok && a < 8'd200) exp_mem[a] = d;
        bus.req[idx] = 1'b0;
        bus.we[idx]  = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},  32'(bus.grant),  32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_busy"},   32'(clear_busy), 32'd0);
        check({tag, "_done"},   32'(clear_done), 32'd0);
        check({tag, "_wren"},   32'(ram_wren),   32'd0);
        check({tag, "_addr"},   32'(ram_addr),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Preload RAM under reset; every cell nonzero.
        for (int i = 0; i < 256; i++) begin
            pre_en     = 1'b1;
            pre_addr   = 8'(i);
            pre_data   = (i == 5) ? 6'h2A : 6'((i % 63) + 1);
            exp_mem[i] = pre_data;
            tick();
        end
        pre_en = 1'b0;
        check_idle_outputs("reset");

        reset_n = 1'b1;
        tick();
        tick();

        // Single read of cell 5.
        bus.addr[7:0] = 8'd5;
        bus.req       = 3'b001;
        tick();
        check("single_grant", 32'(bus.grant), 32'b001);
        check("single_addr", 32'(ram_addr), 32'd5);
        push_rd(0, 6'h2A);
        tick();
        check("single_rvalid", 32'(bus.rvalid), 32'b001);
        check("single_rdata", 32'(bus.rdata), 32'h2A);
        bus.req = '0;
        tick();
        check("single_release", 32'(bus.grant), 32'd0);
        tick();

        // Out-of-range read returns zero; writes at the range boundary.
        do_read(2, 8'd250);
        do_write(1, 8'd200, 6'h3F);
        check("oor_no_write", 32'(mem[200]), 32'(exp_mem[200]));
        do_write(1, 8'd199, 6'h15);
        do_read(2, 8'd199);
        do_read(0, 8'd37);

        // Contention from a fresh reset: 16-cycle bursts 001,010,100,001.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        bus.addr  = {8'd230, 8'd220, 8'd210};
        bus.we    = 3'b111;
        bus.req   = 3'b111;
        for (int k = 0; k < 64; k++) begin
            tick();
            check($sformatf("contend_grant_%0d", k), 32'(bus.grant), 32'(1 << ((k / 16) % 3)));
            check("contend_wren", 32'(ram_wren), 32'd0);
        end
        bus.req = '0;
        tick();
        tick();
        check("contend_idle", 32'(bus.grant), 32'd0);

        // Lone owner saturates and keeps the grant; a newcomer takes over.
        bus.we  = 3'b011;
        bus.req = 3'b010;
        tick();
        check("sat_grant", 32'(bus.grant), 32'b010);
        for (int k = 0; k < 40; k++) tick();
        check("sat_hold", 32'(bus.grant), 32'b010);
        bus.req = 3'b011;
        tick();
        check("sat_handoff", 32'(bus.grant), 32'b001);
        bus.req = '0;
        bus.we  = '0;
        tick();
        tick();

        // Clear while requester 0 holds a read grant.
        begin
            bit ok;
            bus.addr[7:0] = 8'd10;
            bus.req       = 3'b001;
            wait_grant(0, ok);
            if (ok) push_rd(0, exp_mem[10]);
            clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
            check("clr_grant0", 32'(bus.grant), 32'd0);
            check("clr_busy1", 32'(clear_busy), 32'd1);
            for (int k = 0; k < 200; k++) begin
                check($sformatf("clr_addr_%0d", k), 32'(ram_addr), 32'(k));
                check("clr_wren", 32'(ram_wren), 32'd1);
                check("clr_data", 32'(ram_data), 32'd0);
                check("clr_grant", 32'(bus.grant), 32'd0);
                check("clr_done_low", 32'(clear_done), 32'd0);
                clear_start = (k == 20);
                tick();
            end
            clear_start = 1'b0;
            for (int i = 0; i < 200; i++) exp_mem[i] = '0;
            check("clr_done", 32'(clear_done), 32'd1);
            check("clr_busy_end", 32'(clear_busy), 32'd0);
            check("clr_regrant", 32'(bus.grant), 32'b001);
            push_rd(0, 6'd0);
            tick();
            check("clr_done_pulse", 32'(clear_done), 32'd0);
            bus.req = '0;
            tick();
            tick();
        end
        do_read(1, 8'd150);

        // Refill RAM, then reset in the middle of a clear.
        for (int i = 0; i < 256; i++) begin
            pre_en     = 1'b1;
            pre_addr   = 8'(i);
            pre_data   = 6'(((i * 3) % 61) + 2);
            exp_mem[i] = pre_data;
            tick();
        end
        pre_en = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            check("mc_addr", 32'(ram_addr), 32'(k));
            tick();
        end
        check("mc_addr50", 32'(ram_addr), 32'd50);
        check("mc_wren50", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mc_wren_in_reset", 32'(ram_wren), 32'd0);
        tick();
        check_idle_outputs("mc_reset");
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mc_no_done", 32'(clear_done), 32'd0);
            check("mc_not_busy", 32'(clear_busy), 32'd0);
        end
        for (int i = 0; i < 50; i++) exp_mem[i] = '0;
        check("mc_mem0", 32'(mem[0]), 32'd0);
        check("mc_mem49", 32'(mem[49]), 32'd0);
        check("mc_mem50", 32'(mem[50]), 32'(exp_mem[50]));
        check("mc_mem199", 32'(mem[199]), 32'(exp_mem[199]));
        do_read(0, 8'd120);
        do_read(2, 8'd30);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 Parameter NUM_CELLS, default 200, meaning the number of valid board cells (10x20), addresses 0..NUM_CELLS-1.
REQ-002 Parameter MAX_BURST, default 16, meaning the maximum consecutive granted cycles while another requester waits.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset.
REQ-005 Port req  input  3  per-requester access request; bit 0 = collision, 1 = add-to-RAM, 2 = line-clear.
REQ-006 Port we  input  3  per-requester write enable; 0 = read.
REQ-007 Port addr  input  24  requester i address at bits [8i+7:8i].
REQ-008 Port wdata  input  18  requester i write data at bits [6i+5:6i].
REQ-009 Port grant  output  3  one-hot registered grant, or all zero.
REQ-010 Port rvalid  output  3  per-requester read-data-valid pulse.
REQ-011 Port rdata  output  6  read data, shared by all requesters, qualified by rvalid.
REQ-012 Port clear_start  input  1  single-cycle request to zero the whole board.
REQ-013 Port clear_busy  output  1  high while the clear sequence runs.
REQ-014 Port clear_done  output  1  one-cycle pulse when the clear completes.
REQ-015 Port ram_addr  output  8  board RAM address.
REQ-016 Port ram_data  output  6  board RAM write data.
REQ-017 Port ram_wren  output  1  board RAM write enable.
REQ-018 Port ram_q  input  6  board RAM read data, valid one cycle after the address.

Function
REQ-019 The block SHALL use states ARB (normal arbitration) and CLEAR; ARB -> CLEAR on clear_start; CLEAR -> ARB after the last cell is written.
REQ-020 Acceptance: in ARB, an access SHALL be accepted in any cycle with grant[i] & req[i]; ram_addr, ram_wren and ram_data SHALL then come combinationally from requester i.
REQ-021 When no access is accepted and the state is not CLEAR, ram_wren SHALL be 0 and ram_addr SHALL be 0.
REQ-022 New grant: with no current owner, the next grant SHALL go to the requesting bit found first in round-robin order, starting after the last owner; it SHALL be visible the cycle after req is sampled.
REQ-023 Release: the owner SHALL be released at a clock edge when req[owner] = 0, or when the burst counter reaches MAX_BURST-1 while any other req bit is set.
REQ-024 Handoff: on release, the next owner SHALL be chosen at the same edge, with the releasing owner at lowest priority; no idle cycle is inserted.
REQ-025 Burst counter: it SHALL clear on each new grant, increment per granted cycle, and saturate at MAX_BURST-1 when no other requester waits; the owner then keeps the grant.
REQ-026 Read response: rvalid[i] SHALL pulse exactly one cycle after an accepted read (we[i] = 0); rdata SHALL equal ram_q in that cycle.
REQ-027 Out-of-range address (>= NUM_CELLS): a write SHALL be suppressed (ram_wren = 0); a read SHALL still pulse rvalid with rdata = 0.
REQ-028 Clear start: clear_start in ARB SHALL drive grant to 0 and clear_busy to 1 at the next edge, pre-empting any owner; the round-robin pointer SHALL be kept.
REQ-029 Clear writes: in CLEAR, the block SHALL write ram_data = 0 to addresses 0..NUM_CELLS-1, one per cycle in ascending order, with ram_wren = 1, taking NUM_CELLS cycles.
REQ-030 Clear end: in the cycle after the last write, clear_done SHALL pulse and clear_busy SHALL be 0; arbitration resumes and a grant may appear at that same edge.
REQ-031 clear_start SHALL be ignored while clear_busy = 1.
REQ-032 An rvalid owed from a read accepted in the cycle before a clear starts SHALL still be delivered.
REQ-033 Requests SHALL be held, not dropped, during CLEAR.

Reset
REQ-034 While reset_n = 0 at an edge: grant, rvalid, clear_busy, clear_done, ram_wren and ram_addr SHALL be 0; state SHALL be ARB; the round-robin pointer SHALL select requester 0 first; the burst counter SHALL be 0.
REQ-035 A reset during CLEAR SHALL abort the sequence, leave the remaining cells untouched, and produce no clear_done.

Verification
REQ-036 Single read: req = 001, addr0 = 5, RAM[5] = 0x2A -> grant = 001 one cycle later; rvalid[0] and rdata = 0x2A one cycle after acceptance.
REQ-037 Contention: req = 111 held -> grants 001, 010, 100, 001, each lasting exactly 16 cycles, with no gap cycles.
REQ-038 Write out of range: requester 1 writes addr 200 -> ram_wren stays 0; a write to addr 199 -> ram_wren = 1, ram_addr = 199.
REQ-039 Clear: clear_start while requester 0 is granted -> grant = 0 and clear_busy = 1 next cycle, 200 zero writes to addresses 0..199, then a clear_done pulse and requester 0 re-granted.
REQ-040 Reset mid-clear: reset_n low at write 50 -> all outputs 0 next cycle, no clear_done, and RAM[50..199] keep their prior values.
